// File: rtl/axis_pattern_gen_check.sv
// AXIS counting-pattern generator (m_axis) and self-checking sink (s_axis).
// Ports: aclk/arstn/enable, m_axis_* out, s_axis_* in, pkt_sent/pkt_recv/err_count/err/done status.
module axis_pattern_gen_check #(
  parameter int BUS_WIDTH  = 4,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int PKT_BEATS  = 16,
  parameter int TAIL_BYTES = BUS_WIDTH,
  parameter int PKT_COUNT  = 0,
  parameter int RAND_VALID = 0,
  parameter int RAND_READY = 0
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic                   enable,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [8*BUS_WIDTH-1:0] m_axis_tdata,
  output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [8*BUS_WIDTH-1:0] s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]  s_axis_tdest,
  output logic [31:0]            pkt_sent,
  output logic [31:0]            pkt_recv,
  output logic [31:0]            err_count,
  output logic                   err,
  output logic                   done
);

  localparam int DW = 8 * BUS_WIDTH;
  localparam logic [31:0] LAST_BEAT = 32'(PKT_BEATS - 1);
  localparam logic [31:0] PKT_TOTAL = 32'(PKT_COUNT);
  localparam logic [BUS_WIDTH-1:0] KEEP_ALL = '1;
  localparam logic [BUS_WIDTH-1:0] KEEP_TAIL =
    KEEP_ALL >> (BUS_WIDTH - TAIL_BYTES);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [BUS_WIDTH-1:0] keep_for(input logic [31:0] beat);
    return (beat == LAST_BEAT) ? KEEP_TAIL : KEEP_ALL;
  endfunction

  // Unkept bytes are forced to zero.
  function automatic logic [DW-1:0] beat_data(
    input logic [31:0]          seq,
    input logic [BUS_WIDTH-1:0] keep
  );
    logic [DW-1:0] d;
    logic [31:0]   base;
    d    = '0;
    base = seq * 32'(BUS_WIDTH);
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (keep[i]) d[8*i +: 8] = 8'(base + 32'(i));
    end
    return d;
  endfunction

  // ---------------- generator ----------------
  logic [0:0]            state_q, state_d;
  logic [31:0]           seq_q, seq_d;
  logic [31:0]           beat_q, beat_d;
  logic [31:0]           pn_q, pn_d;
  logic [31:0]           sent_q, sent_d;
  logic [15:0]           glfsr_q;
  logic [DW-1:0]         tdata_q, tdata_d;
  logic [BUS_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                  m_hs, all_sent, go, load;

  always_comb begin
    m_hs   = (state_q == ST_VALID) && m_axis_tready;
    seq_d  = seq_q;
    beat_d = beat_q;
    pn_d   = pn_q;
    sent_d = sent_q;
    if (m_hs) begin
      seq_d = seq_q + 32'd1;
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        pn_d   = pn_q + 32'd1;
        sent_d = sent_q + 32'd1;
      end else begin
        beat_d = beat_q + 32'd1;
      end
    end
    // Uses the post-handshake count so the final beat never repeats.
    all_sent = (PKT_COUNT != 0) && (sent_d == PKT_TOTAL);
    go = enable && !all_sent && ((RAND_VALID == 0) || glfsr_q[0]);
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (go) state_d = ST_VALID;
    end else if (m_hs) begin
      state_d = go ? ST_VALID : ST_IDLE;
    end
    load    = go && ((state_q == ST_IDLE) || m_hs);
    tkeep_d = keep_for(beat_d);
    tdata_d = beat_data(seq_d, tkeep_d);
    tlast_d = (beat_d == LAST_BEAT);
    tuser_d = pn_d[USER_WIDTH-1:0];
    tdest_d = pn_d[DEST_WIDTH-1:0];
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      beat_q  <= '0;
      pn_q    <= '0;
      sent_q  <= '0;
      glfsr_q <= 16'hACE1;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
      tuser_q <= '0;
      tdest_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      beat_q  <= beat_d;
      pn_q    <= pn_d;
      sent_q  <= sent_d;
      glfsr_q <= lfsr_next(glfsr_q);
      if (load) begin
        tdata_q <= tdata_d;
        tkeep_q <= tkeep_d;
        tlast_q <= tlast_d;
        tuser_q <= tuser_d;
        tdest_q <= tdest_d;
      end
    end
  end

  assign m_axis_tvalid = (state_q == ST_VALID);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdest  = tdest_q;
  assign pkt_sent      = sent_q;

  // ---------------- checker ----------------
  logic [31:0]          eseq_q, eseq_d;
  logic [31:0]          ebeat_q, ebeat_d;
  logic [31:0]          epn_q, epn_d;
  logic [31:0]          recv_q, recv_d;
  logic [31:0]          errc_q, errc_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 rdy_q, rdy_d;
  logic [15:0]          clfsr_q;
  logic [BUS_WIDTH-1:0] ekeep;
  logic [DW-1:0]        edata, kmask;
  logic                 elast, s_hs, bad, end_pkt;

  always_comb begin
    s_hs  = s_axis_tvalid && rdy_q;
    ekeep = keep_for(ebeat_q);
    edata = beat_data(eseq_q, ekeep);
    elast = (ebeat_q == LAST_BEAT);
    kmask = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      kmask[8*i +: 8] = {8{ekeep[i]}};
    end
    bad = (s_axis_tkeep != ekeep)
       || ((s_axis_tdata & kmask) != edata)
       || (s_axis_tlast != elast)
       || (s_axis_tuser != epn_q[USER_WIDTH-1:0])
       || (s_axis_tdest != epn_q[DEST_WIDTH-1:0]);
    end_pkt = s_axis_tlast || elast;
    eseq_d  = eseq_q;
    ebeat_d = ebeat_q;
    epn_d   = epn_q;
    recv_d  = recv_q;
    errc_d  = errc_q;
    err_d   = err_q;
    if (s_hs) begin
      eseq_d = eseq_q + 32'd1;
      if (end_pkt) begin
        ebeat_d = '0;
        epn_d   = epn_q + 32'd1;
        recv_d  = recv_q + 32'd1;
      end else begin
        ebeat_d = ebeat_q + 32'd1;
      end
      if (bad) begin
        err_d = 1'b1;
        if (errc_q != '1) errc_d = errc_q + 32'd1;
      end
    end
    done_d = (PKT_COUNT != 0) && (recv_d == PKT_TOTAL);
    // Ready freezes once the expected traffic is complete.
    if (done_q) begin
      rdy_d = rdy_q;
    end else begin
      rdy_d = (RAND_READY != 0) ? clfsr_q[0] : 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      eseq_q  <= '0;
      ebeat_q <= '0;
      epn_q   <= '0;
      recv_q  <= '0;
      errc_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      clfsr_q <= 16'h1D2C;
    end else begin
      eseq_q  <= eseq_d;
      ebeat_q <= ebeat_d;
      epn_q   <= epn_d;
      recv_q  <= recv_d;
      errc_q  <= errc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      clfsr_q <= lfsr_next(clfsr_q);
    end
  end

  assign s_axis_tready = rdy_q;
  assign pkt_recv      = recv_q;
  assign err_count     = errc_q;
  assign err           = err_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_pattern_gen_check.sv
// Directed bench: loopback instance with fault injection plus a
// randomly throttled loopback instance checked for AXIS stability.
module tb_axis_pattern_gen_check;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic        arstn, enable, hold;
  logic [31:0] cor_mask;
  int          cor_idx;
  logic        a_m_tvalid, a_m_tready, a_m_tlast;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;
  logic        a_m_tuser, a_m_tdest;
  logic        a_s_tvalid, a_s_tready;
  logic [31:0] a_s_tdata;
  logic [31:0] a_sent, a_recv, a_errc;
  logic        a_err, a_done;
  int          hs_n;

  assign a_s_tvalid = a_m_tvalid & ~hold;
  assign a_m_tready = a_s_tready & ~hold;
  assign a_s_tdata  = a_m_tdata ^ ((hs_n == cor_idx) ? cor_mask : 32'h0);

  axis_pattern_gen_check #(
    .BUS_WIDTH(4), .USER_WIDTH(1), .DEST_WIDTH(1), .PKT_BEATS(4),
    .TAIL_BYTES(2), .PKT_COUNT(2), .RAND_VALID(0), .RAND_READY(0)
  ) u_a (
    .aclk(aclk), .arstn(arstn), .enable(enable),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep),
    .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
    .m_axis_tdest(a_m_tdest),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_m_tkeep),
    .s_axis_tlast(a_m_tlast), .s_axis_tuser(a_m_tuser),
    .s_axis_tdest(a_m_tdest),
    .pkt_sent(a_sent), .pkt_recv(a_recv), .err_count(a_errc),
    .err(a_err), .done(a_done)
  );

  always @(posedge aclk or negedge arstn) begin
    if (!arstn) hs_n <= 0;
    else if (a_m_tvalid && a_m_tready) hs_n <= hs_n + 1;
  end

  int          cyc = 0;
  logic [31:0] lg_data[$];
  logic [3:0]  lg_keep[$];
  logic        lg_last[$];
  logic        lg_user[$];
  int          lg_cyc[$];

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (arstn && a_m_tvalid && a_m_tready) begin
      lg_data.push_back(a_m_tdata);
      lg_keep.push_back(a_m_tkeep);
      lg_last.push_back(a_m_tlast);
      lg_user.push_back(a_m_tuser);
      lg_cyc.push_back(cyc);
    end
  end

  // ---------------- instance B ----------------
  logic        arstn_b, enable_b;
  logic        b_tvalid, b_tready, b_tlast, b_tuser, b_tdest;
  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep;
  logic [31:0] b_sent, b_recv, b_errc;
  logic        b_err, b_done;

  axis_pattern_gen_check #(
    .BUS_WIDTH(4), .USER_WIDTH(1), .DEST_WIDTH(1), .PKT_BEATS(4),
    .TAIL_BYTES(4), .PKT_COUNT(100), .RAND_VALID(1), .RAND_READY(1)
  ) u_b (
    .aclk(aclk), .arstn(arstn_b), .enable(enable_b),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .m_axis_tdest(b_tdest),
    .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep),
    .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
    .s_axis_tdest(b_tdest),
    .pkt_sent(b_sent), .pkt_recv(b_recv), .err_count(b_errc),
    .err(b_err), .done(b_done)
  );

  logic        pv = 1'b0, pr = 1'b0;
  logic [38:0] pp = '0;
  int          viol = 0;
  int          stalls = 0;

  always @(negedge aclk) begin
    if (!arstn_b) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        stalls++;
        if (!b_tvalid ||
            pp != {b_tdata, b_tkeep, b_tlast, b_tuser, b_tdest})
          viol++;
      end
      pv = b_tvalid;
      pr = b_tready;
      pp = {b_tdata, b_tkeep, b_tlast, b_tuser, b_tdest};
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    lg_data.delete();
    lg_keep.delete();
    lg_last.delete();
    lg_user.delete();
    lg_cyc.delete();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    repeat (2) @(negedge aclk);
    clear_log();
    arstn = 1'b1;
  endtask

  task automatic wait_a_done(input int budget);
    int n = 0;
    while (!a_done && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (!a_done) chk("a_done_timeout", 0, 1);
  endtask

  logic [31:0] exp_data[8] = '{32'h03020100, 32'h07060504, 32'h0B0A0908,
                               32'h00000D0C, 32'h13121110, 32'h17161514,
                               32'h1B1A1918, 32'h00001D1C};
  logic [3:0]  exp_keep[8] = '{4'hF, 4'hF, 4'hF, 4'h3,
                               4'hF, 4'hF, 4'hF, 4'h3};
  logic        exp_last[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic        exp_user[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    arstn    = 1'b0;
    enable   = 1'b0;
    hold     = 1'b0;
    cor_idx  = 99;
    cor_mask = 32'h0;
    arstn_b  = 1'b0;
    enable_b = 1'b0;

    // reset state
    repeat (2) @(negedge aclk);
    chk("rst_tvalid", a_m_tvalid, 0);
    chk("rst_tdata", a_m_tdata, 0);
    chk("rst_tready", a_s_tready, 0);
    chk("rst_done", a_done, 0);
    arstn = 1'b1;
    #1;
    chk("tready_at_release", a_s_tready, 0);
    @(negedge aclk);
    chk("tready_after_release", a_s_tready, 1);
    chk("tvalid_idle", a_m_tvalid, 0);

    // two-packet loopback, unkept bytes of seq 3 corrupted
    cor_idx  = 3;
    cor_mask = 32'hFFFF0000;
    enable   = 1'b1;
    @(negedge aclk);
    chk("first_tvalid", a_m_tvalid, 1);
    chk("first_tdata", a_m_tdata, 32'h03020100);
    wait_a_done(50);
    chk("beats", lg_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < lg_data.size()) begin
        chk($sformatf("data%0d", i), lg_data[i], exp_data[i]);
        chk($sformatf("keep%0d", i), lg_keep[i], exp_keep[i]);
        chk($sformatf("last%0d", i), lg_last[i], exp_last[i]);
        chk($sformatf("user%0d", i), lg_user[i], exp_user[i]);
      end
    end
    if (lg_cyc.size() == 8) chk("no_bubbles", lg_cyc[7] - lg_cyc[0], 7);
    chk("pkt_sent", a_sent, 2);
    chk("pkt_recv", a_recv, 2);
    chk("err_count_clean", a_errc, 0);
    chk("err_clean", a_err, 0);
    chk("done", a_done, 1);
    chk("tvalid_after_done", a_m_tvalid, 0);

    // bit-0 flip on seq 5
    enable   = 1'b0;
    do_reset();
    cor_idx  = 5;
    cor_mask = 32'h1;
    enable   = 1'b1;
    wait_a_done(50);
    chk("flip_err_count", a_errc, 1);
    chk("flip_err", a_err, 1);
    chk("flip_pkt_recv", a_recv, 2);
    repeat (3) @(negedge aclk);
    chk("flip_err_sticky", a_err, 1);

    // reset during beat 2 of first packet
    enable   = 1'b0;
    cor_mask = 32'h0;
    do_reset();
    enable = 1'b1;
    for (int n = 0; n < 20 && hs_n != 2; n++) @(negedge aclk);
    chk("reach_beat2", hs_n, 2);
    chk("beat2_tdata", a_m_tdata, 32'h0B0A0908);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", a_m_tvalid, 0);
    chk("mid_rst_payload",
        {a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser, a_m_tdest}, 0);
    chk("mid_rst_tready", a_s_tready, 0);
    chk("mid_rst_recv", a_recv, 0);
    @(negedge aclk);
    clear_log();
    arstn = 1'b1;
    wait_a_done(50);
    if (lg_data.size() > 0) begin
      chk("restart_tdata", lg_data[0], 32'h03020100);
      chk("restart_tuser", lg_user[0], 0);
    end else begin
      chk("restart_beats", 0, 1);
    end
    chk("restart_err_count", a_errc, 0);

    // enable dropped while stalled
    enable = 1'b0;
    do_reset();
    hold   = 1'b1;
    enable = 1'b1;
    @(negedge aclk);
    chk("stall_tvalid_rise", a_m_tvalid, 1);
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    chk("stall_tvalid_held", a_m_tvalid, 1);
    chk("stall_tdata_held", a_m_tdata, 32'h03020100);
    @(posedge aclk);
    #1 hold = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("tvalid_drop_after_hs", a_m_tvalid, 0);
    chk("one_beat_sent", lg_data.size(), 1);
    enable = 1'b1;
    wait_a_done(50);
    chk("resume_beats", lg_data.size(), 8);
    if (lg_data.size() > 1) chk("resume_seq1", lg_data[1], 32'h07060504);
    chk("resume_err_count", a_errc, 0);
    chk("resume_pkt_recv", a_recv, 2);

    // random throttling on both sides
    arstn_b = 1'b1;
    @(negedge aclk);
    enable_b = 1'b1;
    for (int n = 0; n < 20000 && !b_done; n++) @(negedge aclk);
    chk("rand_done", b_done, 1);
    chk("rand_pkt_recv", b_recv, 100);
    chk("rand_pkt_sent", b_sent, 100);
    chk("rand_err_count", b_errc, 0);
    chk("rand_stability", viol, 0);
    chk("rand_saw_stalls", stalls > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
